// File: rtl/tube_bus_ctrl.sv
// Tube bus controller: bridges Z80 I/O cycles on the CPC expansion bus to a
// 6502-style Tube register interface. It synthesises PHI2 and steers the
// level-shift buffer. It also provides an interrupt mask with a synchroniser,
// and a stretched Pi reset pulse.
module tube_bus_ctrl #(
    parameter logic [15:0] TUBE_BASE   = 16'hFCE0,
    parameter logic [15:0] CTRL_BASE   = 16'hFCE8,
    parameter int          PHI2_HI_CYC = 2,
    parameter int          RST_STRETCH = 8
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] A,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        M1_B,
    input  logic        T_HIRQ_B,
    output logic        buf_oe_b,
    output logic        buf_atob,
    output logic [2:0]  T_HA,
    output logic        T_HCS_B,
    output logic        T_RNW,
    output logic        T_PHI2,
    output logic        T_HRST_B,
    output logic        int_oe
);

    typedef enum logic [2:0] {IDLE, SETUP, P2HI, HOLD, WAIT_END} state_t;

    localparam logic [2:0] PHI_LAST  = 3'(PHI2_HI_CYC - 1);
    localparam logic [3:0] RST_RLOAD = 4'(RST_STRETCH);

    state_t     state, state_nxt;
    logic       acc, acc_rd, acc_wr, tube_hit, ctrl_hit;
    logic       rnw, rnw_nxt;
    logic [2:0] ha_nxt;
    logic [2:0] phi_cnt;
    logic       irq_en, irq_en_nxt;
    logic       rst_load;
    logic       active_nxt;
    logic       irq_s1, irq_s2;
    logic [3:0] rst_cnt, rst_cnt_nxt;

    // A qualified I/O access: not an interrupt acknowledge, exactly one strobe
    assign acc      = ~IOREQ_B & M1_B & (RD_B ^ WR_B);
    assign acc_rd   = acc & ~RD_B;
    assign acc_wr   = acc & ~WR_B;
    assign tube_hit = (A[15:3] == TUBE_BASE[15:3]);
    assign ctrl_hit = (A[15:3] == CTRL_BASE[15:3]);

    // Next-state logic, address/direction latch values and control actions
    always_comb begin
        state_nxt  = state;
        rnw_nxt    = rnw;
        ha_nxt     = T_HA;
        irq_en_nxt = irq_en;
        rst_load   = 1'b0;
        case (state)
            IDLE: begin
                if (acc && tube_hit) begin
                    state_nxt = SETUP;
                    ha_nxt    = A[2:0];
                    rnw_nxt   = acc_rd;
                end else if (acc && ctrl_hit) begin
                    state_nxt = WAIT_END;
                    if (acc_wr) begin
                        case (A[2:0])
                            3'd0:    irq_en_nxt = 1'b0;
                            3'd1:    irq_en_nxt = 1'b1;
                            3'd2:    rst_load   = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            SETUP:    state_nxt = P2HI;
            // Writes use a fixed PHI2 width; reads stretch until the Z80 ends the cycle
            P2HI: begin
                if (rnw ? IOREQ_B : (phi_cnt == PHI_LAST))
                    state_nxt = HOLD;
            end
            HOLD:     state_nxt = IOREQ_B ? IDLE : WAIT_END;
            // Park here until IOREQ_B rises so one Z80 cycle yields one Tube cycle
            WAIT_END: if (IOREQ_B) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        active_nxt = (state_nxt == SETUP) || (state_nxt == P2HI) || (state_nxt == HOLD);
    end

    // FSM state, latched cycle attributes, PHI2 width counter and IRQ mask
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state   <= IDLE;
            rnw     <= 1'b1;
            T_HA    <= 3'd0;
            phi_cnt <= 3'd0;
            irq_en  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rnw     <= rnw_nxt;
            T_HA    <= ha_nxt;
            phi_cnt <= (state == P2HI) ? phi_cnt + 3'd1 : 3'd0;
            irq_en  <= irq_en_nxt;
        end
    end

    // Registered bus outputs decoded from the next state (no Z80 input reaches a pin combinationally)
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            T_HCS_B  <= 1'b1;
            buf_oe_b <= 1'b1;
            T_PHI2   <= 1'b0;
            T_RNW    <= 1'b1;
            buf_atob <= 1'b1;
        end else begin
            T_HCS_B  <= ~active_nxt;
            buf_oe_b <= ~active_nxt;
            T_PHI2   <= (state_nxt == P2HI);
            T_RNW    <= active_nxt ? rnw_nxt : 1'b1;
            buf_atob <= active_nxt ? ~rnw_nxt : 1'b1;
        end
    end

    // Two-flop synchroniser on the Pi IRQ, then the masked open-drain enable
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
            int_oe <= 1'b0;
        end else begin
            irq_s1 <= T_HIRQ_B;
            irq_s2 <= irq_s1;
            int_oe <= irq_en & ~irq_s2;
        end
    end

    // Pi reset stretch: a command reloads the counter, even mid-pulse
    always_comb begin
        if (rst_load)
            rst_cnt_nxt = RST_RLOAD;
        else if (rst_cnt != 4'd0)
            rst_cnt_nxt = rst_cnt - 4'd1;
        else
            rst_cnt_nxt = 4'd0;
    end

    // Reset counter and registered active-low Pi reset
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            rst_cnt  <= RST_RLOAD;
            T_HRST_B <= 1'b0;
        end else begin
            rst_cnt  <= rst_cnt_nxt;
            T_HRST_B <= (rst_cnt_nxt == 4'd0);
        end
    end

endmodule

// File: doc/tube_bus_ctrl.md
TUBE_BUS_CTRL -- requirements
Module: tube_bus_ctrl

Interface
REQ-001 SHALL have parameter TUBE_BASE, default 16'hFCE0: Tube register window base, decoded on A[15:3].
REQ-002 SHALL have parameter CTRL_BASE, default 16'hFCE8: control window base, decoded on A[15:3]; A[2:0] selects the action.
REQ-003 SHALL have parameter PHI2_HI_CYC, default 2, legal 1..7: PHI2-high length in CLK cycles for writes.
REQ-004 SHALL have parameter RST_STRETCH, default 8, legal 1..15: Pi reset length in CLK cycles.
REQ-005 SHALL have ports, clock and reset first:
- CLK in 1: CPC bus clock. One clock domain; all state updates on the rising edge.
- RESET_B in 1: asynchronous, active-low reset.
- A in 16: Z80 address.
- IOREQ_B, RD_B, WR_B, M1_B in 1 each: Z80 strobes, active-low.
- T_HIRQ_B in 1: Pi interrupt request, active-low, asynchronous.
- buf_oe_b out 1: level-shift buffer enable, active-low.
- buf_atob out 1: buffer direction; 1 = Z80 D to Pi T_HD.
- T_HA out 3: Tube register address.
- T_HCS_B out 1: Tube chip select, active-low.
- T_RNW out 1: 1 = read.
- T_PHI2 out 1: synthesised 6502 phase-2 clock.
- T_HRST_B out 1: Pi reset, active-low.
- int_oe out 1: when 1, the board pulls INT_B low (open-drain drive).

Function
REQ-006 SHALL detect an access on a CLK edge when IOREQ_B=0, M1_B=1, and exactly one of RD_B/WR_B is 0; RD_B=WR_B=0 SHALL be ignored.
REQ-007 SHALL implement FSM states IDLE, SETUP, P2HI, HOLD, WAIT_END.
REQ-008 IDLE with a Tube-window access SHALL go to SETUP and latch the following: T_HA=A[2:0]; T_RNW=1 for a read, 0 for a write.
REQ-009 IDLE with a control-window write SHALL perform the action once and go to WAIT_END:
- A[2:0]=0: irq_en=0.
- A[2:0]=1: irq_en=1.
- A[2:0]=2: start a Pi reset pulse.
- Other values and reads: go to WAIT_END with no action.
REQ-010 Outputs in SETUP SHALL be: T_HCS_B=0, T_PHI2=0, buf_oe_b=0, buf_atob=~T_RNW. Duration is 1 cycle, then P2HI.
REQ-011 P2HI SHALL drive T_PHI2=1, with the other outputs held.
- Write: exit to HOLD after exactly PHI2_HI_CYC cycles, regardless of IOREQ_B.
- Read: exit to HOLD on the first edge where IOREQ_B=1.
REQ-012 HOLD SHALL drive T_PHI2=0, with T_HCS_B, T_HA, T_RNW and the buffer held for 1 cycle.
- Next state is IDLE if IOREQ_B=1, else WAIT_END.
REQ-013 WAIT_END SHALL drive T_HCS_B=1 and buf_oe_b=1, and return to IDLE on the first edge where IOREQ_B=1, so that one Z80 cycle produces at most one Tube cycle.
REQ-014 In IDLE and WAIT_END, outputs SHALL be: T_HCS_B=1, T_PHI2=0, buf_oe_b=1, buf_atob=1, T_RNW=1. T_HA SHALL hold its last value.
REQ-015 All FSM outputs SHALL be registered; none SHALL be driven combinationally from Z80 inputs.
REQ-016 T_HIRQ_B SHALL pass through a 2-flop synchroniser; int_oe = irq_en AND NOT(synchronised T_HIRQ_B), registered.
- Latency from T_HIRQ_B to int_oe is 3 edges.
REQ-017 The Pi reset SHALL use a 4-bit counter loaded with RST_STRETCH.
- T_HRST_B=0 while the counter is nonzero; the counter decrements each cycle.
- A reset-pulse command during an active pulse SHALL reload the counter to RST_STRETCH.
REQ-018 Tube cycles SHALL proceed normally while T_HRST_B=0; the block does not gate them.

Reset
REQ-019 While RESET_B=0, the block SHALL be in the following state:
- FSM = IDLE; irq_en=0; synchroniser flops=1; T_HA=0.
- Outputs as in REQ-014, int_oe=0, T_HRST_B=0.
- Reset counter = RST_STRETCH.
REQ-020 On RESET_B rising, T_HRST_B SHALL stay 0 for exactly RST_STRETCH CLK edges, then go to 1.
REQ-021 Reset asserted mid-cycle SHALL immediately (asynchronously) force T_HCS_B=1, T_PHI2=0 and buf_oe_b=1.

Verification
REQ-022 Write test: OUT to &FCE5 (WR_B=0, IOREQ_B=0 held 6 cycles) -> expected response:
- T_HCS_B=0, T_HA=5, T_RNW=0, buf_atob=1, buf_oe_b=0 for 1+2+1 cycles.
- T_PHI2 high for exactly 2 cycles.
- Then idle values; no second cycle before IOREQ_B rises.
REQ-023 Read test: IN from &FCE2 with IOREQ_B held low 5 cycles -> expected response:
- T_RNW=1, buf_atob=0, T_HA=2.
- T_PHI2 high from SETUP+1 until the edge after IOREQ_B rises, then HOLD 1 cycle, then IDLE.
REQ-024 Negative decode test -> expected response: no T_HCS_B assertion and buffer disabled for each of:
- IN from &FCD7.
- M1_B=0 with IOREQ_B=0 (interrupt acknowledge).
- RD_B=WR_B=0.
REQ-025 Interrupt test -> expected response:
- T_HIRQ_B=0 with irq_en=0: int_oe stays 0.
- OUT to &FCE9: int_oe=1 within 3 edges.
- OUT to &FCE8: int_oe=0.
REQ-026 Pi reset test -> expected response:
- After RESET_B release, T_HRST_B=0 for exactly 8 edges.
- OUT to &FCEA: 8-cycle pulse.
- Second OUT to &FCEA at pulse cycle 5: pulse extends to 13 cycles total.
REQ-027 Reset-abort test: assert RESET_B during P2HI of a write -> expected response:
- T_PHI2=0 and T_HCS_B=1 immediately.
- After release, FSM in IDLE; a new access to &FCE0 completes normally.
